// File: rtl/caesar_clk_gate_ctrl.sv
// caesar_clk_gate_ctrl: idle-driven clock gating for the caesar macro.
// Gates after N idle edges, wakes on demand with a fixed ready latency.
module caesar_clk_gate_ctrl #(
  parameter int CNT_W       = 8,
  parameter int WAKE_CYCLES = 2,
  parameter int EVT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_en_i,
  input  logic [CNT_W-1:0] idle_thresh_i,
  input  logic             req_i,
  input  logic             busy_i,
  output logic             ready_o,
  output logic             clk_en_o,
  output logic             gated_o,
  output logic [EVT_W-1:0] gate_events_o
);

  // State encoding keeps "gated" in a single flop bit, so the
  // clock-enable is a direct flop output and cannot glitch.
  typedef enum logic [1:0] {
    ACTIVE = 2'b00,
    GATED  = 2'b01,
    WAKE   = 2'b10
  } state_t;

  localparam logic [3:0] WAKE_LAST = 4'(WAKE_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] idle_cnt;
  logic [CNT_W-1:0] thresh_m1;
  logic [3:0]       wake_cnt;
  logic [EVT_W-1:0] gate_events;
  logic             idle;
  logic             thresh_hit;
  logic             wake_req;
  logic             wake_done;
  logic             do_gate;
  logic             evt_sat;

  // Idle qualification and terminal-count compares
  always_comb begin
    idle = cfg_en_i & ~req_i & ~busy_i
         & (idle_thresh_i != '0);
    thresh_m1  = idle_thresh_i - 1'b1;
    thresh_hit = (idle_cnt == thresh_m1);
    wake_req   = req_i | busy_i | ~cfg_en_i;
    wake_done  = (wake_cnt == WAKE_LAST);
    do_gate    = (state == ACTIVE) & idle
               & thresh_hit;
    evt_sat    = (gate_events == '1);
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ACTIVE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ACTIVE: begin
        if (do_gate) begin
          state_nxt = GATED;
        end
      end
      GATED: begin
        if (wake_req) begin
          state_nxt = WAKE;
        end
      end
      WAKE: begin
        if (wake_done) begin
          state_nxt = ACTIVE;
        end
      end
      default: begin
        state_nxt = ACTIVE;
      end
    endcase
  end

  // Output decode, purely from the state flops
  always_comb begin
    clk_en_o = ~state[0];
    gated_o  = state[0];
    ready_o  = (state == ACTIVE);
  end

  // Consecutive-idle counter, cleared by any activity
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idle_cnt <= '0;
    end else if (state != ACTIVE) begin
      idle_cnt <= '0;
    end else if (!idle || thresh_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // Wake-latency counter, runs only while in WAKE
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wake_cnt <= '0;
    end else if (state == WAKE) begin
      wake_cnt <= wake_cnt + 1'b1;
    end else begin
      wake_cnt <= '0;
    end
  end

  // Saturating count of ACTIVE->GATED transitions
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gate_events <= '0;
    end else if (do_gate && !evt_sat) begin
      gate_events <= gate_events + 1'b1;
    end
  end

  assign gate_events_o = gate_events;

endmodule

// File: tb/tb_caesar_clk_gate_ctrl.sv
// tb_caesar_clk_gate_ctrl: directed bench for the caesar clock gater.
// Small event counter build so saturation is reachable.
module tb_caesar_clk_gate_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       cfg_en_i;
  logic [7:0] idle_thresh_i;
  logic       req_i;
  logic       busy_i;
  logic       ready_o;
  logic       clk_en_o;
  logic       gated_o;
  logic [1:0] gate_events_o;

  int n_chk  = 0;
  int n_pass = 0;

  caesar_clk_gate_ctrl #(
    .CNT_W(8),
    .WAKE_CYCLES(2),
    .EVT_W(2)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .cfg_en_i(cfg_en_i),
    .idle_thresh_i(idle_thresh_i),
    .req_i(req_i),
    .busy_i(busy_i),
    .ready_o(ready_o),
    .clk_en_o(clk_en_o),
    .gated_o(gated_o),
    .gate_events_o(gate_events_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag,
                     input int got,
                     input int exp);
    n_chk++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  // advance one edge, land 1ns after it
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // wake by request, held until accepted
  task automatic wake_by_req();
    req_i = 1'b1;
    step(3);
    chk("wake_ready", int'(ready_o), 1);
    req_i = 1'b0;
  endtask

  int seen_gated;
  int seen_notready;

  initial begin
    rst_i         = 1'b1;
    cfg_en_i      = 1'b1;
    idle_thresh_i = 8'd4;
    req_i         = 1'b0;
    busy_i        = 1'b0;
    #12;
    chk("rst_clk_en", int'(clk_en_o), 1);
    chk("rst_ready", int'(ready_o), 1);
    chk("rst_gated", int'(gated_o), 0);
    chk("rst_events", int'(gate_events_o), 0);
    rst_i = 1'b0;

    // gate after threshold 4
    step(3);
    chk("thr_edge3_en", int'(clk_en_o), 1);
    step(1);
    chk("thr_edge4_en", int'(clk_en_o), 0);
    chk("thr_gated", int'(gated_o), 1);
    chk("thr_ready", int'(ready_o), 0);
    chk("thr_events", int'(gate_events_o), 1);

    // wake latency, WAKE_CYCLES=2
    req_i = 1'b1;
    step(1);
    chk("wk_t_en", int'(clk_en_o), 1);
    chk("wk_t_ready", int'(ready_o), 0);
    chk("wk_t_gated", int'(gated_o), 0);
    step(1);
    chk("wk_t1_ready", int'(ready_o), 0);
    step(1);
    chk("wk_t2_ready", int'(ready_o), 1);
    step(1);
    chk("wk_t3_en", int'(clk_en_o), 1);
    req_i = 1'b0;

    // busy pulse restarts the idle count
    step(3);
    busy_i = 1'b1;
    step(1);
    busy_i = 1'b0;
    step(3);
    chk("busy_idle3_en", int'(clk_en_o), 1);
    step(1);
    chk("busy_idle4_en", int'(clk_en_o), 0);
    chk("busy_events", int'(gate_events_o), 2);
    wake_by_req();

    // req on the threshold cycle blocks gating
    step(3);
    req_i = 1'b1;
    step(1);
    req_i = 1'b0;
    chk("req_thr_en", int'(clk_en_o), 1);
    step(3);
    chk("req_thr_idle3", int'(clk_en_o), 1);
    step(1);
    chk("req_thr_idle4", int'(gated_o), 1);
    chk("evt_sat3", int'(gate_events_o), 3);
    wake_by_req();

    // threshold 0 never gates
    idle_thresh_i = 8'd0;
    seen_gated = 0;
    for (int i = 0; i < 300; i++) begin
      step(1);
      if (gated_o) seen_gated++;
    end
    chk("thr0_never", seen_gated, 0);

    // threshold 1 gates after one idle edge
    idle_thresh_i = 8'd1;
    step(1);
    chk("thr1_gated", int'(gated_o), 1);
    chk("evt_sat_hold", int'(gate_events_o), 3);

    // cfg drop wakes and holds ACTIVE
    cfg_en_i = 1'b0;
    step(1);
    chk("cfg_wake_en", int'(clk_en_o), 1);
    chk("cfg_wake_rdy", int'(ready_o), 0);
    step(2);
    chk("cfg_active", int'(ready_o), 1);
    seen_notready = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (!ready_o || !clk_en_o) seen_notready++;
    end
    chk("cfg_off_hold", seen_notready, 0);

    // re-gate with thresh 2, then async reset mid-GATED
    cfg_en_i      = 1'b1;
    idle_thresh_i = 8'd2;
    step(2);
    chk("thr2_gated", int'(gated_o), 1);
    #3;
    rst_i = 1'b1;
    #1;
    chk("arst_en", int'(clk_en_o), 1);
    chk("arst_ready", int'(ready_o), 1);
    chk("arst_gated", int'(gated_o), 0);
    chk("arst_events", int'(gate_events_o), 0);
    #2;
    rst_i = 1'b0;

    // counter restarts from zero after reset
    step(2);
    chk("post_rst_gate", int'(gated_o), 1);
    chk("post_rst_evt", int'(gate_events_o), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
